// File: rtl/ncr_seq_ctrl.sv
// Sequential nCr engine: acc = acc*(n-k+i)/i for i = 1..k on one shared 36x36 multiplier and a bit-serial divider.
// Define NCR_OVF_CHECK_EN to enable saturation and early abort when a quotient exceeds 36 bits.
`timescale 1ns/1ps

module ncr_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [35:0] n,
    input  logic [35:0] r,
    output logic        busy,
    output logic        done,
    output logic [35:0] out,
    output logic        err,
    output logic        ovf
);

    typedef enum logic [2:0] {IDLE, SETUP, MUL, DIV, DONE} state_t;

    state_t      state, state_nx;
    logic [35:0] n_q, r_q, k, i, acc, rem;
    logic [71:0] prod;
    logic [6:0]  cnt;

    logic [35:0] n_minus_r, k_c, mul_op;
    logic [36:0] rem_sh, rem_diff;
    logic        q_bit, div_last, ovf_abort;
    logic [71:0] quo_nx;

    // The partial remainder stays below i, so the borrow bit of rem_sh - i is the inverted quotient bit
    always_comb begin
        n_minus_r = n_q - r_q;
        k_c       = (r_q > n_minus_r) ? n_minus_r : r_q;
        mul_op    = n_q - k + i;
        rem_sh    = {rem, prod[71]};
        rem_diff  = rem_sh - {1'b0, i};
        q_bit     = ~rem_diff[36];
        quo_nx    = {prod[70:0], q_bit};
        div_last  = (cnt == 7'd71);
    end

`ifdef NCR_OVF_CHECK_EN
    logic ovf_q;
    assign ovf_abort = div_last && (|quo_nx[71:36]);
    assign ovf       = ovf_q;
`else
    assign ovf_abort = 1'b0;
    assign ovf       = 1'b0;
`endif

    assign busy = (state == SETUP) || (state == MUL) || (state == DIV);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = SETUP;
            SETUP: begin
                if (r_q > n_q)        state_nx = DONE;
                else if (k_c == '0)   state_nx = DONE;
                else                  state_nx = MUL;
            end
            MUL:   state_nx = DIV;
            DIV: begin
                if (div_last) begin
                    if (ovf_abort || (i == k)) state_nx = DONE;
                    else                       state_nx = MUL;
                end
            end
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q   <= '0;
            r_q   <= '0;
            k     <= '0;
            i     <= '0;
            acc   <= '0;
            rem   <= '0;
            prod  <= '0;
            cnt   <= '0;
            out   <= '0;
            err   <= 1'b0;
`ifdef NCR_OVF_CHECK_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_q   <= n;
                        r_q   <= r;
                        err   <= 1'b0;
`ifdef NCR_OVF_CHECK_EN
                        ovf_q <= 1'b0;
`endif
                    end
                end
                SETUP: begin
                    k   <= k_c;
                    acc <= 36'd1;
                    i   <= 36'd1;
                    if (r_q > n_q) begin
                        err <= 1'b1;
                        out <= '0;
                    end else if (k_c == '0) begin
                        out <= 36'd1;
                    end
                end
                MUL: begin
                    prod <= {36'd0, acc} * {36'd0, mul_op};
                    rem  <= '0;
                    cnt  <= '0;
                end
                DIV: begin
                    prod <= quo_nx;
                    rem  <= q_bit ? rem_diff[35:0] : rem_sh[35:0];
                    cnt  <= cnt + 7'd1;
                    if (div_last) begin
                        acc <= quo_nx[35:0];
                        if (ovf_abort) begin
                            out   <= 36'hF_FFFF_FFFF;
`ifdef NCR_OVF_CHECK_EN
                            ovf_q <= 1'b1;
`endif
                        end else if (i == k) begin
                            out <= quo_nx[35:0];
                        end else begin
                            i <= i + 36'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
